// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared Smith-Waterman types, base codes and score helpers
package sw_pkg;

  // Two-bit nucleotide encoding used on every base lane of the array
  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_G = 2'b01;
  localparam logic [1:0] BASE_T = 2'b10;
  localparam logic [1:0] BASE_C = 2'b11;

  localparam int SCORE_WIDTH_DEF = 12;

  // Scores are carried offset by half the range so "zero" sits at the midpoint
  function automatic logic [31:0] zero_bias(input int width);
    return 32'd1 << (width - 1);
  endfunction

  // One-hot feeder states
  typedef enum logic [3:0] {
    ST_LOAD   = 4'b0001,
    ST_PREP   = 4'b0010,
    ST_STREAM = 4'b0100,
    ST_DRAIN  = 4'b1000
  } feeder_state_t;

endpackage

// File: rtl/sw_base_buffer.sv
// rtl/sw_base_buffer.sv - 2-bit x DEPTH simple dual-port RAM with registered read
module sw_base_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_data
);

  logic [1:0] mem [DEPTH];

  // Write port: one base per accepted host beat
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: data appears the cycle after the address is presented
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sw_target_feeder.sv
// rtl/sw_target_feeder.sv - buffers a host target sequence and bursts it into PE #0
module sw_target_feeder
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = SCORE_WIDTH_DEF,
  parameter int MAX_LEN     = 256,
  parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             s_base,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  input  logic                   done_in,
  output logic                   en_out,
  output logic [1:0]             data_out,
  output logic [SCORE_WIDTH-1:0] M_out,
  output logic [SCORE_WIDTH-1:0] I_out,
  output logic [SCORE_WIDTH-1:0] High_out,
  output logic [LEN_W-1:0]       len_out,
  output logic                   busy,
  output logic                   trunc
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(zero_bias(SCORE_WIDTH));

  feeder_state_t    state, state_next;
  logic [LEN_W-1:0] wptr, rptr;
  logic             xfer, at_max, final_beat;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [1:0]       rd_data;

  // Boundary scores never change, so they hold even while reset is asserted
  assign M_out    = ZERO;
  assign I_out    = ZERO;
  assign High_out = ZERO;

  assign xfer       = s_valid & s_ready & (state == ST_LOAD);
  assign at_max     = (wptr == LEN_W'(MAX_LEN - 1));
  assign final_beat = xfer & (s_last | at_max);

  // PREP fetches base 0; STREAM keeps the read one address ahead of the output
  assign rd_en   = (state == ST_PREP) | (state == ST_STREAM);
  assign rd_addr = (state == ST_PREP) ? '0 : rptr[AW-1:0];

  sw_base_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (xfer),
    .wr_addr (wptr[AW-1:0]),
    .wr_data (s_base),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_LOAD;
    else      state <= state_next;
  end

  // Next state: done_in only matters once the burst has fully left
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD:   if (final_beat) state_next = ST_PREP;
      ST_PREP:   state_next = ST_STREAM;
      ST_STREAM: if (rptr == len_out) state_next = ST_DRAIN;
      ST_DRAIN:  if (done_in) state_next = ST_LOAD;
      default:   state_next = ST_LOAD;
    endcase
  end

  // Pointers, length/trunc bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      len_out  <= '0;
      trunc    <= 1'b0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      en_out   <= 1'b0;
      data_out <= 2'b00;
    end else begin
      s_ready  <= (state_next == ST_LOAD);
      busy     <= (state_next != ST_LOAD);
      en_out   <= (state == ST_STREAM);
      data_out <= (state == ST_STREAM) ? rd_data : 2'b00;

      // Every beat rewrites trunc, so the first beat of a new load clears it
      if (xfer) begin
        wptr  <= wptr + LEN_W'(1);
        trunc <= at_max & ~s_last;
      end
      if (final_beat) len_out <= wptr + LEN_W'(1);

      // rptr counts bases already requested from the RAM
      if (state == ST_PREP)        rptr <= LEN_W'(1);
      else if (state == ST_STREAM) rptr <= rptr + LEN_W'(1);

      if (state == ST_DRAIN && done_in) wptr <= '0;
    end
  end

endmodule

// File: tb/tb_sw_target_feeder.sv
// tb/tb_sw_target_feeder.sv - table-driven bench for sw_target_feeder
module tb_sw_target_feeder;

  localparam int SW    = 12;
  localparam int ML    = 8;
  localparam int LW    = 4;
  localparam int ZEROV = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    s_base = 2'b00;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          done_in = 1'b0;
  logic          en_out;
  logic [1:0]    data_out;
  logic [SW-1:0] M_out, I_out, High_out;
  logic [LW-1:0] len_out;
  logic          busy;
  logic          trunc;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          n;
    logic [19:0] bases;      // base i at bits [2i+1:2i]
    int          last_at;    // beat index carrying s_last, -1 for none
    int          gap_at;     // 3 idle cycles after this beat, -1 for none
    bit          done_mid;   // pulse done_in while streaming
    int          exp_len;
    bit          exp_trunc;
  } vec_t;

  vec_t vecs [5];

  sw_target_feeder #(
    .SCORE_WIDTH (SW),
    .MAX_LEN     (ML),
    .LEN_W       (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_base   (s_base),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .done_in  (done_in),
    .en_out   (en_out),
    .data_out (data_out),
    .M_out    (M_out),
    .I_out    (I_out),
    .High_out (High_out),
    .len_out  (len_out),
    .busy     (busy),
    .trunc    (trunc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic send(input logic [1:0] b, input logic l);
    int guard = 0;
    s_valid = 1'b1;
    s_base  = b;
    s_last  = l;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      send(v.bases[2*i +: 2], i == v.last_at);
      if (i == 0) chk("trunc_cleared_first_beat", 32'(trunc), 32'd0);
      if (i == v.gap_at) begin
        repeat (3) @(negedge clk);
        chk("s_ready_in_gap", 32'(s_ready), 32'd1);
      end
    end
  endtask

  task automatic run_vector(input vec_t v);
    logic       e_en;
    logic [1:0] e_d;
    int         idx;
    load_vec(v);
    // k counts negedges after the final handshake edge; burst occupies k=2..len+1
    for (int k = 0; k < v.exp_len + 4; k++) begin
      if (k > 0) @(negedge clk);
      e_en = (k >= 2) && (k < 2 + v.exp_len);
      idx  = e_en ? k - 2 : 0;
      e_d  = e_en ? v.bases[2*idx +: 2] : 2'b00;
      chk("en_out", 32'(en_out), 32'(e_en));
      chk("data_out", 32'(data_out), 32'(e_d));
      chk("s_ready_busy_phase", 32'(s_ready), 32'd0);
      done_in = v.done_mid && (k == 3);
    end
    done_in = 1'b0;
    chk("len_out", 32'(len_out), 32'(v.exp_len));
    chk("trunc", 32'(trunc), 32'(v.exp_trunc));
    chk("busy_drain", 32'(busy), 32'd1);
    // Host offers a junk beat during DRAIN; it must not be taken
    s_valid = 1'b1;
    s_base  = 2'b11;
    s_last  = 1'b1;
    repeat (20) @(negedge clk);
    chk("s_ready_before_done", 32'(s_ready), 32'd0);
    chk("en_out_drain", 32'(en_out), 32'd0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    chk("s_ready_after_done", 32'(s_ready), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t fresh;
    // A,G,T,C back-to-back
    vecs[0] = '{n: 4, bases: 20'h000e4, last_at: 3, gap_at: -1, done_mid: 1'b0, exp_len: 4, exp_trunc: 1'b0};
    // same bases with a 3-cycle gap between beats 2 and 3, done_in during stream
    vecs[1] = '{n: 4, bases: 20'h000e4, last_at: 3, gap_at: 1, done_mid: 1'b1, exp_len: 4, exp_trunc: 1'b0};
    // single base G
    vecs[2] = '{n: 1, bases: 20'h00001, last_at: 0, gap_at: -1, done_mid: 1'b0, exp_len: 1, exp_trunc: 1'b0};
    // A,G,T,C,C,T,G,A with no s_last: cut at MAX_LEN
    vecs[3] = '{n: 8, bases: 20'h01be4, last_at: -1, gap_at: -1, done_mid: 1'b0, exp_len: 8, exp_trunc: 1'b1};
    // host's beats 9 and 10 (T,C) form the next load
    vecs[4] = '{n: 2, bases: 20'h0000e, last_at: 1, gap_at: -1, done_mid: 1'b0, exp_len: 2, exp_trunc: 1'b0};
    // T,A,G
    fresh   = '{n: 3, bases: 20'h00012, last_at: 2, gap_at: -1, done_mid: 1'b0, exp_len: 3, exp_trunc: 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_en_out", 32'(en_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_len_out", 32'(len_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trunc", 32'(trunc), 32'd0);
    chk("rst_M_out", 32'(M_out), ZEROV);
    chk("rst_I_out", 32'(I_out), ZEROV);
    chk("rst_High_out", 32'(High_out), ZEROV);
    rst = 1'b1;
    @(negedge clk);
    chk("s_ready_after_release", 32'(s_ready), 32'd1);

    for (int v = 0; v < 5; v++) run_vector(vecs[v]);

    // Reset in the second cycle of a 4-base burst
    load_vec(vecs[0]);
    repeat (3) @(negedge clk);
    chk("midstream_en_before_rst", 32'(en_out), 32'd1);
    chk("midstream_data_before_rst", 32'(data_out), 32'(2'b01));
    rst = 1'b0;
    #1;
    chk("async_rst_en_out", 32'(en_out), 32'd0);
    chk("async_rst_data_out", 32'(data_out), 32'd0);
    chk("async_rst_s_ready", 32'(s_ready), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_len_out", 32'(len_out), 32'd0);
    chk("async_rst_M_out", 32'(M_out), ZEROV);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("s_ready_after_midstream_rst", 32'(s_ready), 32'd1);
    run_vector(fresh);

    chk("final_High_out", 32'(High_out), ZEROV);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sw_target_feeder.md
Name: sw_target_feeder

Overview:
Upstream stage of the Smith-Waterman systolic array. It drives the left-boundary inputs of PE #0.
- Accepts a target sequence from the host, one 2-bit base per valid/ready beat, into an internal buffer.
- Once the whole sequence is loaded, streams it to the array as one contiguous en_out burst, one base per cycle.
- Drives the biased-zero boundary scores (M, I, High).
- Holds off the next sequence until the array reports completion through the last PE's vld.

Parameters:
SCORE_WIDTH, 12, score width in bits; must match the PE array.
MAX_LEN, 256, maximum target length in bases; must be ≥2.
LEN_W, $clog2(MAX_LEN+1), width of length counters.
ZERO, 2**(SCORE_WIDTH-1), biased zero score.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
s_base  in  2  target base (A=00, G=01, T=10, C=11)
s_valid  in  1  host beat valid
s_last  in  1  marks the final base of the sequence
s_ready  out  1  feeder accepts a beat
done_in  in  1  vld of the last PE in the array
en_out  out  1  to PE#0 en_in
data_out  out  2  to PE#0 data_in
M_out  out  SCORE_WIDTH  to PE#0 M_in, constant ZERO
I_out  out  SCORE_WIDTH  to PE#0 I_in, constant ZERO
High_out  out  SCORE_WIDTH  to PE#0 High_in, constant ZERO
len_out  out  LEN_W  length of the current/last sequence
busy  out  1  high in every state except LOAD
trunc  out  1  sticky: last sequence was cut at MAX_LEN

Behaviour:
- Reset (rst=0, async, any state):
  - state=LOAD; write pointer and read pointer = 0.
  - en_out=0, data_out=00, s_ready=0, len_out=0, busy=0, trunc=0.
  - M_out/I_out/High_out=ZERO at all times, including during reset.
- All outputs are registered. s_ready goes 1 in the first clock after reset release, and whenever state=LOAD.
- Handshake: a beat transfers on a clk edge with s_valid & s_ready. The base is written to buf[wptr] and wptr is incremented. s_valid may drop between beats; no data is lost or duplicated.
- State LOAD:
  - Transfer with s_last=1, or the MAX_LEN-th transfer → len_out=wptr+1, trunc=(MAX_LEN-th beat & ~s_last), s_ready=0 next cycle, go PREP.
  - s_last on the very first beat gives a length-1 sequence. Zero-length sequences cannot occur.
  - trunc clears on the first transfer of the next load.
- State PREP (1 cycle): read buf[0]; go STREAM.
- State STREAM:
  - en_out=1 for exactly len_out consecutive cycles.
  - data_out=buf[k] in cycle k, k=0..len_out-1. No bubbles.
  - After the last base, go DRAIN.
  - done_in is ignored in STREAM.
- Latency: the first en_out=1 cycle is exactly 2 clocks after the s_last handshake edge (1 for the LOAD→PREP register, 1 for PREP).
- State DRAIN:
  - en_out=0, data_out=00.
  - Waits for done_in=1 (a 1-cycle pulse), then goes LOAD and sets wptr=0.
  - s_ready=1 in the following cycle.
  - en_out therefore always has ≥1 low cycle between bursts, which the PE array's reset-to-idle behaviour requires.
- data_out=00 whenever en_out=0.
- busy=1 in PREP/STREAM/DRAIN.
- Buffer: MAX_LEN×2 simple dual-port, synchronous read. Write happens only in LOAD and read only in PREP/STREAM, so there is no read/write collision.
- Reset mid-STREAM: en_out drops to 0 immediately (async). The sequence is discarded; the host must resend.

Decomposition:
- Shared package (sw_pkg): base codes _A/_G/_T/_C, SCORE_WIDTH default, ZERO bias function, feeder state encoding (one-hot, 4 states).
- One sub-module: sw_base_buffer, a parameterized 2-bit × MAX_LEN synchronous-read RAM.
- FSM, pointers and output registers stay in sw_target_feeder.

Test Plan:
- Load A,G,T,C (s_last on C), back-to-back beats → en_out high cycles N+2..N+5 with data_out 00,01,10,11; len_out=4; trunc=0; s_ready=0 until done_in.
- Same 4 bases with s_valid low for 3 cycles between beats 2 and 3 → identical burst; no duplicated or missing base.
- MAX_LEN=8, host sends 10 beats without s_last → 8-cycle burst of the first 8 bases; trunc=1; len_out=8. Remaining beats are accepted only after done_in, as the start of the next load, which clears trunc.
- done_in pulsed during STREAM → ignored. Pulse in DRAIN 20 cycles later → s_ready=1 the next cycle; the next burst is preceded by ≥1 en_out=0 cycle.
- Single-base sequence (s_last on first beat) → en_out high exactly 1 cycle; len_out=1.
- Assert rst mid-STREAM (cycle 2 of 4) → en_out=0 and data_out=00 asynchronously; after release, s_ready=1 next clk; a fresh 3-base load streams correctly.
